// File: rtl/fir_pkg.sv
// Shared definitions for the complex decimating FIR: FSM state type,
// accumulator width helper and the fixed-point dequantize function.
package fir_pkg;

  typedef enum logic [1:0] {
    S_SHIFT,
    S_MAC,
    S_WRITE
  } state_t;

  // Working width for dq(); wide enough for a 2*64-bit product difference.
  localparam int DQ_W = 130;

  // Accumulator width that cannot overflow when summing NUM_TAPS dequantized terms.
  function automatic int acc_w(input int data_w, input int num_taps);
    return data_w + $clog2(num_taps) + 1;
  endfunction

  // Signed division by 2^frac_bits, truncating toward zero.
  function automatic logic signed [DQ_W-1:0] dq(input logic signed [DQ_W-1:0] v,
                                                input int frac_bits);
    logic signed [DQ_W-1:0] bias;
    bias = '0;
    if (v < 0) bias = (DQ_W'(1) <<< frac_bits) - DQ_W'(1);
    return (v + bias) >>> frac_bits;
  endfunction

endpackage

// File: rtl/fir_cmplx_decim_mac.sv
// Complex multiply-accumulate: one registered tap product set per cycle,
// followed by dequantize-and-accumulate of the previous tap's products.
module cmplx_mac
  import fir_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 10,
  parameter int ACC_W     = 38
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en_mul,
  input  logic                     en_acc,
  input  logic signed [DATA_W-1:0] xr,
  input  logic signed [DATA_W-1:0] xi,
  input  logic signed [DATA_W-1:0] cr,
  input  logic signed [DATA_W-1:0] ci,
  output logic signed [ACC_W-1:0]  acc_r,
  output logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  acc_r_nxt,
  output logic signed [ACC_W-1:0]  acc_i_nxt
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    rr_p0, ii_p0, ri_p0, ir_p0;
  logic signed [PW:0]      re_sum_p0, im_sum_p0;
  logic signed [ACC_W-1:0] acc_r_p1, acc_i_p1;

  // Stage 0: register the four partial products of the current tap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_p0 <= '0;
      ii_p0 <= '0;
      ri_p0 <= '0;
      ir_p0 <= '0;
    end else if (en_mul) begin
      rr_p0 <= PW'(xr) * PW'(cr);
      ii_p0 <= PW'(xi) * PW'(ci);
      ri_p0 <= PW'(cr) * PW'(xi);
      ir_p0 <= PW'(ci) * PW'(xr);
    end
  end

  // Combine products, dequantize and form the next accumulator values.
  always_comb begin
    re_sum_p0 = (PW+1)'(rr_p0) - (PW+1)'(ii_p0);
    im_sum_p0 = (PW+1)'(ri_p0) + (PW+1)'(ir_p0);
    acc_r_nxt = acc_r_p1 + ACC_W'(dq(DQ_W'(re_sum_p0), FRAC_BITS));
    acc_i_nxt = acc_i_p1 + ACC_W'(dq(DQ_W'(im_sum_p0), FRAC_BITS));
  end

  // Stage 1: accumulators, cleared once a result has been handed off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r_p1 <= '0;
      acc_i_p1 <= '0;
    end else if (clear) begin
      acc_r_p1 <= '0;
      acc_i_p1 <= '0;
    end else if (en_acc) begin
      acc_r_p1 <= acc_r_nxt;
      acc_i_p1 <= acc_i_nxt;
    end
  end

  assign acc_r = acc_r_p1;
  assign acc_i = acc_i_p1;

endmodule

// File: rtl/fir_cmplx_decim.sv
// Complex-coefficient decimating FIR between paired input and output FIFOs.
// Optional build macro FIR_CMPLX_SAT_EN: saturate the result to DATA_W on
// output instead of wrapping to the low DATA_W bits.
module fir_cmplx_decim
  import fir_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 10,
  parameter int NUM_TAPS   = 20,
  parameter int DECIMATION = 1,
  parameter logic [0:NUM_TAPS-1][DATA_W-1:0] COEFF_REAL = '0,
  parameter logic [0:NUM_TAPS-1][DATA_W-1:0] COEFF_IMAG = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] xreal_in_dout,
  input  logic [DATA_W-1:0] ximag_in_dout,
  input  logic              xreal_in_empty,
  input  logic              ximag_in_empty,
  output logic              xreal_in_rd_en,
  output logic              ximag_in_rd_en,
  output logic [DATA_W-1:0] yreal_out_din,
  output logic [DATA_W-1:0] yimag_out_din,
  input  logic              yreal_out_full,
  input  logic              yimag_out_full,
  output logic              yreal_out_wr_en,
  output logic              yimag_out_wr_en
);

  localparam int ACC_W = acc_w(DATA_W, NUM_TAPS);
  localparam int K_W   = $clog2(NUM_TAPS + 1);
  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam int PH_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [K_W-1:0]  K_LAST  = K_W'(NUM_TAPS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIMATION - 1);

`ifdef FIR_CMPLX_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
`endif

  // Narrow an accumulator to the output width.
  function automatic logic signed [DATA_W-1:0] to_out(input logic signed [ACC_W-1:0] a);
`ifdef FIR_CMPLX_SAT_EN
    if (a > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (a < SAT_LO) return SAT_LO[DATA_W-1:0];
    return a[DATA_W-1:0];
`else
    return a[DATA_W-1:0];
`endif
  endfunction

  state_t                  state, state_nxt;
  logic [K_W-1:0]          k;
  logic [PH_W-1:0]         phase;
  logic [TAP_W-1:0]        tap;
  logic                    rd_en, wr_en, mac_clear, en_mul, en_acc;
  logic signed [DATA_W-1:0] dly_r [NUM_TAPS];
  logic signed [DATA_W-1:0] dly_i [NUM_TAPS];
  logic signed [DATA_W-1:0] cr_sel, ci_sel;
  logic signed [ACC_W-1:0]  acc_r, acc_i, acc_r_nxt, acc_i_nxt;
  logic signed [DATA_W-1:0] din_r, din_i;

  assign xreal_in_rd_en  = rd_en;
  assign ximag_in_rd_en  = rd_en;
  assign yreal_out_wr_en = wr_en;
  assign yimag_out_wr_en = wr_en;
  assign yreal_out_din   = din_r;
  assign yimag_out_din   = din_i;

  assign tap    = (k < K_LAST) ? k[TAP_W-1:0] : '0;
  assign cr_sel = COEFF_REAL[tap];
  assign ci_sel = COEFF_IMAG[tap];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_SHIFT;
    else        state <= state_nxt;
  end

  // Next state plus the combinational FIFO strobes and MAC controls.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mac_clear = 1'b0;
    en_mul    = 1'b0;
    en_acc    = 1'b0;
    case (state)
      S_SHIFT: begin
        if (!xreal_in_empty && !ximag_in_empty) begin
          rd_en = 1'b1;
          if (phase == PH_LAST) state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        en_mul = (k != K_LAST);
        en_acc = (k != '0);
        if (k == K_LAST) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (!yreal_out_full && !yimag_out_full) begin
          wr_en     = 1'b1;
          mac_clear = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      default: state_nxt = S_SHIFT;
    endcase
  end

  // Decimation phase and tap counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      k     <= '0;
    end else begin
      if (rd_en) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      if (state == S_MAC && k != K_LAST) k <= k + 1'b1;
      else if (wr_en)                     k <= '0;
    end
  end

  // Delay lines: newest sample enters at index 0 on every pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        dly_r[i] <= '0;
        dly_i[i] <= '0;
      end
    end else if (rd_en) begin
      dly_r[0] <= xreal_in_dout;
      dly_i[0] <= ximag_in_dout;
      for (int i = 1; i < NUM_TAPS; i++) begin
        dly_r[i] <= dly_r[i-1];
        dly_i[i] <= dly_i[i-1];
      end
    end
  end

  cmplx_mac #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clear    (mac_clear),
    .en_mul   (en_mul),
    .en_acc   (en_acc),
    .xr       (dly_r[tap]),
    .xi       (dly_i[tap]),
    .cr       (cr_sel),
    .ci       (ci_sel),
    .acc_r    (acc_r),
    .acc_i    (acc_i),
    .acc_r_nxt(acc_r_nxt),
    .acc_i_nxt(acc_i_nxt)
  );

  // Output stage: capture the final accumulation so din is ready in S_WRITE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      din_r <= '0;
      din_i <= '0;
    end else if (state == S_MAC && k == K_LAST) begin
      din_r <= to_out(acc_r_nxt);
      din_i <= to_out(acc_i_nxt);
    end
  end

  // Registered accumulators are only consumed through acc_*_nxt here.
  logic unused_acc;
  assign unused_acc = ^{acc_r, acc_i};

endmodule

// File: tb/tb_fir_cmplx_decim.sv
// Directed bench for fir_cmplx_decim: identity, impulse, rotation,
// decimation, backpressure, mid-MAC reset and output narrowing.
module tb_fir_cmplx_decim;

  logic clock, reset;
  logic [31:0] xr [5];
  logic [31:0] xi [5];
  logic er [5], ei [5], fr [5], fi [5];
  logic rdr [5], rdi [5], wrr [5], wri [5];
  logic [31:0] yr [5];
  logic [31:0] yi [5];
  logic [15:0] yr_s, yi_s;
  int n_cmp, n_bad;
  int wcnt [5];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign yr[4] = {{16{yr_s[15]}}, yr_s};
  assign yi[4] = {{16{yi_s[15]}}, yi_s};

  fir_cmplx_decim #(.DATA_W(32), .FRAC_BITS(10), .NUM_TAPS(4), .DECIMATION(1),
    .COEFF_REAL({32'sd1024, 32'sd0, 32'sd0, 32'sd0}),
    .COEFF_IMAG({32'sd0, 32'sd0, 32'sd0, 32'sd0})
  ) u_id (.clock(clock), .reset(reset),
    .xreal_in_dout(xr[0]), .ximag_in_dout(xi[0]), .xreal_in_empty(er[0]), .ximag_in_empty(ei[0]),
    .xreal_in_rd_en(rdr[0]), .ximag_in_rd_en(rdi[0]), .yreal_out_din(yr[0]), .yimag_out_din(yi[0]),
    .yreal_out_full(fr[0]), .yimag_out_full(fi[0]), .yreal_out_wr_en(wrr[0]), .yimag_out_wr_en(wri[0]));

  fir_cmplx_decim #(.DATA_W(32), .FRAC_BITS(10), .NUM_TAPS(4), .DECIMATION(1),
    .COEFF_REAL({32'sd1024, 32'sd512, -32'sd256, 32'sd7}),
    .COEFF_IMAG({32'sd0, 32'sd1024, 32'sd0, -32'sd1024})
  ) u_imp (.clock(clock), .reset(reset),
    .xreal_in_dout(xr[1]), .ximag_in_dout(xi[1]), .xreal_in_empty(er[1]), .ximag_in_empty(ei[1]),
    .xreal_in_rd_en(rdr[1]), .ximag_in_rd_en(rdi[1]), .yreal_out_din(yr[1]), .yimag_out_din(yi[1]),
    .yreal_out_full(fr[1]), .yimag_out_full(fi[1]), .yreal_out_wr_en(wrr[1]), .yimag_out_wr_en(wri[1]));

  fir_cmplx_decim #(.DATA_W(32), .FRAC_BITS(10), .NUM_TAPS(4), .DECIMATION(1),
    .COEFF_REAL({32'sd0, 32'sd0, 32'sd0, 32'sd0}),
    .COEFF_IMAG({32'sd1024, 32'sd0, 32'sd0, 32'sd0})
  ) u_rot (.clock(clock), .reset(reset),
    .xreal_in_dout(xr[2]), .ximag_in_dout(xi[2]), .xreal_in_empty(er[2]), .ximag_in_empty(ei[2]),
    .xreal_in_rd_en(rdr[2]), .ximag_in_rd_en(rdi[2]), .yreal_out_din(yr[2]), .yimag_out_din(yi[2]),
    .yreal_out_full(fr[2]), .yimag_out_full(fi[2]), .yreal_out_wr_en(wrr[2]), .yimag_out_wr_en(wri[2]));

  fir_cmplx_decim #(.DATA_W(32), .FRAC_BITS(10), .NUM_TAPS(4), .DECIMATION(2),
    .COEFF_REAL({32'sd1024, 32'sd0, 32'sd0, 32'sd0}),
    .COEFF_IMAG({32'sd0, 32'sd0, 32'sd0, 32'sd0})
  ) u_dec (.clock(clock), .reset(reset),
    .xreal_in_dout(xr[3]), .ximag_in_dout(xi[3]), .xreal_in_empty(er[3]), .ximag_in_empty(ei[3]),
    .xreal_in_rd_en(rdr[3]), .ximag_in_rd_en(rdi[3]), .yreal_out_din(yr[3]), .yimag_out_din(yi[3]),
    .yreal_out_full(fr[3]), .yimag_out_full(fi[3]), .yreal_out_wr_en(wrr[3]), .yimag_out_wr_en(wri[3]));

  fir_cmplx_decim #(.DATA_W(16), .FRAC_BITS(10), .NUM_TAPS(4), .DECIMATION(1),
    .COEFF_REAL({16'sd1024, 16'sd1024, 16'sd1024, 16'sd1024}),
    .COEFF_IMAG({16'sd0, 16'sd0, 16'sd0, 16'sd0})
  ) u_sat (.clock(clock), .reset(reset),
    .xreal_in_dout(xr[4][15:0]), .ximag_in_dout(xi[4][15:0]), .xreal_in_empty(er[4]), .ximag_in_empty(ei[4]),
    .xreal_in_rd_en(rdr[4]), .ximag_in_rd_en(rdi[4]), .yreal_out_din(yr_s), .yimag_out_din(yi_s),
    .yreal_out_full(fr[4]), .yimag_out_full(fi[4]), .yreal_out_wr_en(wrr[4]), .yimag_out_wr_en(wri[4]));

  // Count completed writes per instance.
  always @(negedge clock) begin
    for (int i = 0; i < 5; i++)
      if (wrr[i] && wri[i]) wcnt[i] <= wcnt[i] + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample to instance i and wait until it is popped.
  task automatic push(input int i, input int r, input int m);
    int n;
    n = 0;
    @(negedge clock);
    xr[i] = r; xi[i] = m; er[i] = 1'b0; ei[i] = 1'b0;
    #1;
    while (!(rdr[i] && rdi[i]) && n < 200) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 200) check("rd_timeout", 0, 1);
    @(posedge clock); #1;
    er[i] = 1'b1; ei[i] = 1'b1;
  endtask

  // Wait for the next write of instance i; lat counts negedges waited.
  task automatic get(input int i, output int r, output int m, output int lat);
    lat = 0;
    r = 0; m = 0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (wrr[i] && wri[i]) begin
        r = yr[i]; m = yi[i];
        break;
      end
    end
    if (lat >= 200) check("wr_timeout", 0, 1);
  endtask

  int r, m, lat, w0, seen_rd, seen_wr;
  int imp_r [8] = '{1024, 512, -256, 7, 1, 0, 0, 0};
  int imp_i [8] = '{0, 1024, 0, -1024, 0, 1, 0, -1};
  int imp_x [8] = '{1024, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      xr[i] = '0; xi[i] = '0; er[i] = 1'b1; ei[i] = 1'b1; fr[i] = 1'b0; fi[i] = 1'b0;
      wcnt[i] = 0;
    end
    #12;
    check("rst_rd_en", int'(rdr[0]), 0);
    check("rst_wr_en", int'(wrr[0]), 0);
    check("rst_din_r", yr[0], 0);
    check("rst_din_i", yi[0], 0);
    @(negedge clock);
    reset = 1'b1;

    // Identity filter and latency from read to write.
    push(0, 5, -3);
    get(0, r, m, lat);
    check("id_real", r, 5);
    check("id_imag", m, -3);
    check("id_latency", lat, 6);

    // Impulse response, then truncation toward zero of fractional taps.
    for (int n = 0; n < 8; n++) begin
      push(1, imp_x[n], 0);
      get(1, r, m, lat);
      check($sformatf("imp_real%0d", n), r, imp_r[n]);
      check($sformatf("imp_imag%0d", n), m, imp_i[n]);
    end

    // Multiply by j.
    push(2, 100, 200);
    get(2, r, m, lat);
    check("rot_real0", r, -200);
    check("rot_imag0", m, 100);
    push(2, -7, 0);
    get(2, r, m, lat);
    check("rot_real1", r, 0);
    check("rot_imag1", m, -7);

    // Decimation by two.
    w0 = wcnt[3];
    push(3, 1, 1);
    push(3, 2, 2);
    get(3, r, m, lat);
    check("dec_real0", r, 2);
    check("dec_imag0", m, 2);
    push(3, 3, 3);
    push(3, 4, 4);
    get(3, r, m, lat);
    check("dec_real1", r, 4);
    check("dec_imag1", m, 4);
    repeat (10) @(negedge clock);
    check("dec_count", wcnt[3] - w0, 2);

    // Only one FIFO non-empty: nothing is popped.
    seen_rd = 0;
    @(negedge clock);
    er[3] = 1'b0; ei[3] = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (rdr[3] || rdi[3]) seen_rd = 1;
    end
    er[3] = 1'b1;
    check("half_empty_rd", seen_rd, 0);

    // Backpressure on the imaginary output FIFO.
    fi[0] = 1'b1;
    push(0, 9, 4);
    er[0] = 1'b0; ei[0] = 1'b0;
    seen_rd = 0; seen_wr = 0;
    repeat (16) begin
      @(negedge clock);
      if (rdr[0] || rdi[0]) seen_rd = 1;
      if (wrr[0] || wri[0]) seen_wr = 1;
    end
    check("bp_no_write", seen_wr, 0);
    check("bp_no_read", seen_rd, 0);
    @(posedge clock); #1;
    fi[0] = 1'b0; er[0] = 1'b1; ei[0] = 1'b1;
    get(0, r, m, lat);
    check("bp_real", r, 9);
    check("bp_imag", m, 4);
    check("bp_latency", lat, 1);

    // Reset in the middle of a MAC run discards the result.
    push(0, 11, 11);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en", int'(wrr[0]), 0);
    check("mid_rst_rd_en", int'(rdr[0]), 0);
    check("mid_rst_din_r", yr[0], 0);
    check("mid_rst_din_i", yi[0], 0);
    w0 = wcnt[0];
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    check("mid_rst_no_write", wcnt[0] - w0, 0);

    // Output narrowing on a 16-bit instance.
    for (int n = 0; n < 4; n++) begin
      push(4, 30000, 0);
      get(4, r, m, lat);
    end
`ifdef FIR_CMPLX_SAT_EN
    check("sat_real", r, 32767);
`else
    check("sat_real", r, -11072);
`endif
    check("sat_imag", m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
